// File: rtl/fire4_expand3_bias_act.sv
// fire4_expand3_bias_act: bias add, optional ReLU (FIRE4_EXPAND3_RELU_EN), shift and saturate for the fire4 expand3x3 stream
module fire4_expand3_bias_act #(
    parameter int CH     = 128,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 4,
    parameter int PIXELS = 3025
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] bias_mem [0:CH-1],
    input  logic [ACC_W-1:0] acc_data,
    input  logic             acc_valid,
    output logic             acc_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [6:0]       out_chan,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);
    localparam int PW = PIXELS > 1 ? $clog2(PIXELS) : 1;

    logic                    en;
    logic [6:0]              chan_cnt;
    logic [PW-1:0]           pix_cnt;
    logic [ACC_W-1:0]        bias;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_sum;
    logic [6:0]              s1_chan;
    logic                    s1_last;
    logic signed [ACC_W-1:0] rect;
    logic signed [ACC_W-1:0] sh;
    logic [OUT_W-1:0]        act;

    assign en        = !out_valid || out_ready;
    assign acc_ready = en;
    assign bias      = bias_mem[chan_cnt];
    assign sum       = $signed({acc_data[ACC_W-1], acc_data}) + $signed({bias[ACC_W-1], bias});
    assign sum_sat   = (sum[ACC_W] != sum[ACC_W-1]) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`ifdef FIRE4_EXPAND3_RELU_EN
    assign rect      = s1_sum[ACC_W-1] ? '0 : s1_sum;
`else
    assign rect      = s1_sum;
`endif
    assign sh        = rect >>> SHIFT;
    assign act       = ((&sh[ACC_W-1:OUT_W-1]) || !(|sh[ACC_W-1:OUT_W-1])) ? sh[OUT_W-1:0]
                     : {sh[ACC_W-1], {(OUT_W-1){~sh[ACC_W-1]}}};

    // channel counter advances on every accepted input beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chan_cnt <= '0;
        else if (acc_valid && en) chan_cnt <= (chan_cnt == 7'(CH-1)) ? '0 : chan_cnt + 7'd1;
    end

    // stage 1: saturated bias add with channel/last sideband
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_chan  <= '0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= acc_valid;
            if (acc_valid) begin
                s1_sum  <= sum_sat;
                s1_chan <= chan_cnt;
                s1_last <= chan_cnt == 7'(CH-1);
            end
        end
    end

    // stage 2: rectify, shift, clamp into the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= act;
                out_chan <= s1_chan;
                out_last <= s1_last;
            end
        end
    end

    // pixel counter; frame_done fires the cycle after the frame's final beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (out_valid && out_ready && out_last) begin
            pix_cnt    <= (pix_cnt == PW'(PIXELS-1)) ? '0 : pix_cnt + PW'(1);
            frame_done <= pix_cnt == PW'(PIXELS-1);
        end else begin
            frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fire4_expand3_bias_act.sv
// tb_fire4_expand3_bias_act: table vectors plus randomized scoreboard against a arithmetic model
module tb_fire4_expand3_bias_act;
    typedef struct {
        int          chan;
        logic [31:0] acc;
        logic [31:0] bias;
        int          exp_relu;
        int          exp_norelu;
    } vec_t;

    typedef struct {
        int  data;
        int  chan;
        bit  last;
    } beat_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] bias [0:127];
    logic [31:0] acc_data = 0;
    logic        acc_valid = 0;
    logic        acc_ready;
    logic [15:0] out_data;
    logic [6:0]  out_chan;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1;
    logic        frame_done;

    int    tests = 0;
    int    fails = 0;
    beat_t q[$];
    int    m_chan = 0;
    int    m_pix = 0;
    bit    fd_exp = 0;
    int    fd_seen = 0;
    bit    rand_rdy = 0;
    int    d_chan = 0;
    logic [31:0] pix_acc [0:127];
    bit    tbl_on [0:127];
    int    tbl_exp [0:127];
    vec_t  vt [7];

    fire4_expand3_bias_act #(.PIXELS(2)) dut (
        .clk(clk), .rst(rst), .bias_mem(bias),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int model(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef FIRE4_EXPAND3_RELU_EN
        if (s < 0) s = 0;
`endif
        s = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic logic [31:0] rnd_acc();
        return ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4000000)) - 32'd2000000;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard and frame_done checker, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (fd_exp || frame_done) begin
                tests++;
                if (frame_done !== fd_exp) begin
                    fails++;
                    $display("FAIL frame_done: got %b want %b", frame_done, fd_exp);
                end
            end
            if (frame_done) fd_seen++;
            fd_exp = 0;
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: chan %0d data %0d with no beat expected", out_chan, $signed(out_data));
                end else if (int'($signed(out_data)) != q[0].data || int'(out_chan) != q[0].chan || out_last !== q[0].last) begin
                    fails++;
                    $display("FAIL out_beat: got data %0d chan %0d last %b want data %0d chan %0d last %b",
                             $signed(out_data), out_chan, out_last, q[0].data, q[0].chan, q[0].last);
                end
                if (out_ready && tbl_on[out_chan]) begin
                    tests++;
                    if (int'($signed(out_data)) != tbl_exp[out_chan]) begin
                        fails++;
                        $display("FAIL vector_ch%0d: got %0d want %0d", out_chan, $signed(out_data), tbl_exp[out_chan]);
                    end
                end
                if (out_ready && q.size() > 0) begin
                    if (q[0].last) begin
                        m_pix++;
                        if (m_pix == 2) begin
                            m_pix = 0;
                            fd_exp = 1;
                        end
                    end
                    void'(q.pop_front());
                end
            end
            if (acc_valid && acc_ready) begin
                q.push_back('{model(acc_data, bias[m_chan]), m_chan, m_chan == 127});
                m_chan = (m_chan + 1) % 128;
            end
        end
    end

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int budget;
            acc_valid = 1;
            acc_data  = pix_acc[d_chan];
            budget    = 0;
            do begin
                @(negedge clk);
                ok = acc_ready;
                @(posedge clk);
                #1;
                budget++;
            end while (!ok && budget < 1000);
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: acc_ready %b want 1", acc_ready);
                acc_valid = 0;
                return;
            end
            d_chan = (d_chan + 1) % 128;
        end
        acc_valid = 0;
    endtask

    task automatic drain();
        int budget = 0;
        while (q.size() > 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding want 0", q.size());
        end
    endtask

    task automatic rand_pixel();
        for (int c = 0; c < 128; c++) pix_acc[c] = rnd_acc();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        vt[0] = '{0,  32'd1000,        -32'sd61,  58,     58};
        vt[1] = '{3,  -32'sd1000,      32'd266,   0,      -46};
        vt[2] = '{16, 32'h7FFFFFF0,    32'd279,   32767,  32767};
        vt[3] = '{20, 32'd100000,      32'd0,     6250,   6250};
        vt[4] = '{30, 32'h80000005,    -32'sd100, 0,      -32768};
        vt[5] = '{40, 32'd524272,      32'd0,     32767,  32767};
        vt[6] = '{41, -32'sd524304,    32'd0,     0,      -32768};
        for (int c = 0; c < 128; c++) begin
            bias[c]    = 32'($urandom_range(0, 2000000)) - 32'd1000000;
            tbl_on[c]  = 0;
            tbl_exp[c] = 0;
        end
        for (int i = 0; i < 7; i++) bias[vt[i].chan] = vt[i].bias;
        #12;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        @(posedge clk);
        #2;
        rst = 0;
        check("idle_acc_ready", 32'(acc_ready), 1);

        rand_pixel();
        for (int i = 0; i < 7; i++) begin
            pix_acc[vt[i].chan] = vt[i].acc;
`ifdef FIRE4_EXPAND3_RELU_EN
            tbl_exp[vt[i].chan] = vt[i].exp_relu;
`else
            tbl_exp[vt[i].chan] = vt[i].exp_norelu;
`endif
            tbl_on[vt[i].chan] = 1;
        end
        stream(1);
        @(negedge clk);
        check("lat_ch0_not_yet", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_ch0_valid", 32'(out_valid), 1);
        check("lat_ch0_chan", 32'(out_chan), 0);
        @(posedge clk);
        #1;
        stream(127);
        drain();
        for (int c = 0; c < 128; c++) tbl_on[c] = 0;

        rand_rdy = 1;
        rand_pixel();
        stream(128);
        drain();
        check("frame_pulses_1", 32'(fd_seen), 1);

        rand_pixel();
        stream(60);
        acc_valid = 1;
        acc_data  = pix_acc[d_chan];
        #1;
        rst = 1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        acc_valid = 0;
        @(negedge clk);
        q.delete();
        m_chan = 0;
        m_pix  = 0;
        fd_exp = 0;
        d_chan = 0;
        @(posedge clk);
        #2;
        rst = 0;

        rand_pixel();
        stream(128);
        rand_pixel();
        stream(128);
        drain();
        check("frame_pulses_2", 32'(fd_seen), 2);

        rand_rdy = 0;
        stream(1);
        drain();
        check("restart_chan0", 32'(out_chan), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
